gcd_engine: RTL

- Self-contained parametrised GCD engine: control FSM plus datapath in one block.
- Successor to the fixed 8-bit subtract-only GCD control unit. Adds a valid/ready handshake on input and output, a runtime-selectable algorithm (subtractive Euclid or binary Stein), a cycle counter and a synchronous abort.
- Sits between a register-mapped operand source and a result consumer in the arithmetic coprocessor.

---
 rtl/gcd_engine.sv | 99 +++++++++
 1 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: handshaked GCD engine with subtractive Euclid or binary Stein steps, cycle counter and abort
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles
);
  localparam int KW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, a_n, b_n, res_n;
  logic [KW-1:0] k_r, k_n;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic mode_r, term;
  assign in_ready  = state == IDLE;
  assign busy      = state == RUN;
  assign out_valid = state == DONE;
  assign cnt_inc   = &cnt ? cnt : cnt + CNT_W'(1);
  always_comb begin
    a_n = a_r;
    b_n = b_r;
    k_n = k_r;
    term = 1'b0;
    res_n = a_r;
    if (!mode_r) begin
      if (b_r == '0) term = 1'b1;
      else if (a_r < b_r) begin
        a_n = b_r;
        b_n = a_r;
      end else a_n = a_r - b_r;
    end else begin
      if (a_r == '0) begin
        term = 1'b1;
        res_n = b_r << k_r;
      end else if (b_r == '0) begin
        term = 1'b1;
        res_n = a_r << k_r;
      end else if (!a_r[0] && !b_r[0]) begin
        a_n = a_r >> 1;
        b_n = b_r >> 1;
        k_n = k_r + KW'(1);
      end else if (!a_r[0]) a_n = a_r >> 1;
      else if (!b_r[0]) b_n = b_r >> 1;
      else if (a_r >= b_r) a_n = (a_r - b_r) >> 1;
      else b_n = (b_r - a_r) >> 1;
    end
  end
  // abort outranks both termination and the consumer handshake
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? RUN : IDLE;
      RUN:     state_n = abort ? IDLE : term ? DONE : RUN;
      DONE:    state_n = (abort || out_ready) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      k_r <= '0;
      mode_r <= 1'b0;
      cnt <= '0;
      result <= '0;
      cycles <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a_in;
      b_r <= b_in;
      mode_r <= mode;
      k_r <= '0;
      cnt <= '0;
    end else if (state == RUN && !abort) begin
      a_r <= a_n;
      b_r <= b_n;
      k_r <= k_n;
      cnt <= cnt_inc;
      if (term) begin
        result <= res_n;
        cycles <= cnt_inc;
      end
    end
  end
endmodule
